if_fetch_unit: RTL



---
 rtl/if_fetch_unit_pkg.sv | 20 ++
 rtl/if_fetch_unit_fetch_fifo.sv | 72 +++++++
 rtl/if_fetch_unit.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: word width, the NOP
// encoding used for IF/ID bubbles and the {pc, inst} fetch-buffer entry.
package if_fetch_unit_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    // Clears the byte-offset bits so a redirect always lands on a word.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/if_fetch_unit_fetch_fifo.sv
// Small synchronous FIFO buffering fetched {pc, inst} words between the
// memory response and the IF/ID register. Push and pop in the same cycle are
// allowed even when full; flush empties it in one cycle.
module if_fetch_unit_fetch_fifo
    import if_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t mem_q [DEPTH];
    fetch_entry_t mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // FIFO state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order word fetches under a
// credit limit of BUF_DEPTH (outstanding + buffered), buffers responses and
// feeds the IF/ID register one instruction per cycle. EX redirects squash
// wrong-path words via a drop counter.
// Build option: define IF_MISALIGN_TRAP_EN to make a misaligned redirect set a
// sticky if_misalign flag and stop fetching; otherwise the target is
// word-aligned and if_misalign stays 0.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_stall_flag,
    input  logic            ex_take_branch,
    input  logic [XLEN-1:0] ex_target_pc,
    output logic            if_mem_req_valid,
    output logic [XLEN-1:0] if_mem_req_addr,
    input  logic            mem_req_ready,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic [XLEN-1:0] if_id_IR,
    output logic [XLEN-1:0] if_id_PC,
    output logic [XLEN-1:0] if_id_NPC,
    output logic            if_id_valid_inst,
    output logic            if_misalign
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [XLEN-1:0] ir_q, ir_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] npc_q, npc_d;
    logic            valid_q, valid_d;

    logic            fifo_push, fifo_pop, fifo_flush, fifo_empty;
    logic [CW-1:0]   fifo_count;
    fetch_entry_t    fifo_head, rsp_entry;

    logic [CW:0]     in_use;
    logic            credit_ok, req_fire, rsp_live, fetch_block;
    logic [XLEN-1:0] redirect_pc;

`ifdef IF_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;

    assign redirect_pc = ex_target_pc;
    assign fetch_block = misalign_q;
    assign if_misalign = misalign_q;

    // Sticky trap: any misaligned redirect latches until reset.
    always_comb begin
        misalign_d = misalign_q | (ex_take_branch & (ex_target_pc[1:0] != 2'b00));
    end

    // Misalign flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) misalign_q <= 1'b0;
        else     misalign_q <= misalign_d;
    end
`else
    assign redirect_pc = align_word(ex_target_pc);
    assign fetch_block = 1'b0;
    assign if_misalign = 1'b0;
`endif

    // Credit: never have more words in flight or buffered than the FIFO holds,
    // so a stalled decode can never overflow the buffer.
    assign in_use    = {1'b0, outst_q} + {1'b0, fifo_count};
    assign credit_ok = (in_use < (CW+1)'(BUF_DEPTH));

    assign if_mem_req_valid = !rst && !ex_take_branch && !fetch_block && credit_ok;
    assign if_mem_req_addr  = fetch_pc_q;
    assign req_fire         = if_mem_req_valid && mem_req_ready;

    // A response is kept only if no squash is pending and no redirect is
    // happening right now; otherwise it belongs to the wrong path.
    assign rsp_live  = mem_rsp_valid && (drop_q == '0) && !ex_take_branch;
    assign rsp_entry = '{pc: rsp_pc_q, inst: mem_rsp_data};

    if_fetch_unit_fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (rsp_entry),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    // PC/credit bookkeeping, FIFO control and IF/ID next value.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        outst_d    = outst_q + CW'(req_fire) - CW'(mem_rsp_valid);
        drop_d     = drop_q;
        ir_d       = ir_q;
        pc_d       = pc_q;
        npc_d      = npc_q;
        valid_d    = valid_q;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;

        if (ex_take_branch) begin
            fetch_pc_d = redirect_pc;
            rsp_pc_d   = redirect_pc;
            fifo_flush = 1'b1;
            ir_d       = NOP;
            valid_d    = 1'b0;
            // Everything still in flight is wrong-path; a response landing this
            // cycle is discarded here, so it is not counted again.
            drop_d     = outst_q - CW'(mem_rsp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (mem_rsp_valid && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
            if (rsp_live) begin
                rsp_pc_d = rsp_pc_q + 32'd4;
            end
            if (id_stall_flag) begin
                fifo_push = rsp_live;
            end else if (!fifo_empty) begin
                fifo_pop  = 1'b1;
                fifo_push = rsp_live;
                ir_d      = fifo_head.inst;
                pc_d      = fifo_head.pc;
                npc_d     = fifo_head.pc + 32'd4;
                valid_d   = 1'b1;
            end else if (rsp_live) begin
                ir_d      = mem_rsp_data;
                pc_d      = rsp_pc_q;
                npc_d     = rsp_pc_q + 32'd4;
                valid_d   = 1'b1;
            end else begin
                ir_d      = NOP;
                valid_d   = 1'b0;
            end
        end
    end

    // Fetch state and IF/ID pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            ir_q       <= NOP;
            pc_q       <= '0;
            npc_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            ir_q       <= ir_d;
            pc_q       <= pc_d;
            npc_q      <= npc_d;
            valid_q    <= valid_d;
        end
    end

    assign if_id_IR         = ir_q;
    assign if_id_PC         = pc_q;
    assign if_id_NPC        = npc_q;
    assign if_id_valid_inst = valid_q;

endmodule
